// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: turns encode requests into 32-bit words and
// writes them to instruction memory at an auto-incrementing byte pointer.
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_base_i,
  input  logic [31:0] base_addr_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [31:0] target_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  output logic        err_o,
  output logic [15:0] count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] ptr;
  logic [31:0] diff;
  logic [31:0] offset;
  logic [31:0] word;
  logic        legal;

  // Word encoding and legality; branch offsets are relative to ptr + 4
  always_comb begin
    word   = '0;
    legal  = 1'b1;
    diff   = target_i - (ptr + 32'd4);
    offset = $signed(diff) >>> 2;
    case (kind_i)
      3'd0: word = {6'h00, rs_i, rt_i, rd_i, shamt_i, funct_i};
      3'd1, 3'd2: begin
        legal = (target_i[1:0] == 2'b00) &&
                ((offset[31:15] == '0) || (offset[31:15] == '1));
        word  = {(kind_i == 3'd1) ? 6'h04 : 6'h05, rs_i, rt_i, offset[15:0]};
      end
      3'd3: word = {6'h08, rs_i, rt_i, imm_i};
      3'd4: word = {6'h09, rs_i, rt_i, imm_i};
      3'd5: word = {6'h0F, 5'd0, rt_i, imm_i};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // A base load in IDLE takes priority and swallows any simultaneous request
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!load_base_i && req_valid_i)
          state_next = legal ? WRITE : ERR;
      end
      WRITE: begin
        if (mem_ready_i) state_next = IDLE;
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr         <= '0;
      count_o     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_base_i) begin
            ptr     <= base_addr_i & 32'hFFFF_FFFC;
            count_o <= '0;
          end else if (req_valid_i && legal) begin
            mem_addr_o  <= ptr;
            mem_wdata_o <= word;
          end
        end
        WRITE: begin
          if (mem_ready_i) begin
            ptr <= ptr + 32'd4;
            if (count_o != 16'hFFFF) count_o <= count_o + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state == IDLE);
  assign mem_we_o    = (state == WRITE);
  assign err_o       = (state == ERR);

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against an arithmetic
// model of the encoding rules, pointer and word counter.
module tb_instr_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_base_i;
  logic [31:0] base_addr_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  kind_i;
  logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
  logic [5:0]  funct_i;
  logic [15:0] imm_i;
  logic [31:0] target_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        err_o;
  logic [15:0] count_o;

  localparam longint TWO32 = 64'sd4294967296;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelPtr = '0;
  int          modelCount = 0;
  logic [31:0] seenAddr, seenWord;
  logic        seenErr;

  instr_encoder dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_base_i(load_base_i),
    .base_addr_i(base_addr_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i),
    .rd_i(rd_i), .shamt_i(shamt_i), .funct_i(funct_i), .imm_i(imm_i),
    .target_i(target_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .err_o(err_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Encoding rules written as field weights and plain integer offset math
  function automatic void modelEncode(input longint k, rs, rt, rd, sh, fn,
                                      imm, tgt, ptr, output bit ok,
                                      output longint word);
    longint opc[6] = '{0, 4, 5, 8, 9, 15};
    longint d, off, field, rsf;
    ok = 1'b1;
    word = 0;
    if (k > 5) begin
      ok = 1'b0;
      return;
    end
    if (k == 0) begin
      word = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
      return;
    end
    field = imm;
    rsf = (k == 5) ? 0 : rs;
    if (k == 1 || k == 2) begin
      d = tgt - ptr - 4;
      if (d < -(TWO32 / 2)) d += TWO32;
      if (d >= TWO32 / 2) d -= TWO32;
      off = d / 4;
      ok = (tgt % 4 == 0) && (off >= -32768) && (off <= 32767);
      field = (off < 0) ? off + 65536 : off;
    end
    word = opc[k] * 67108864 + rsf * 2097152 + rt * 65536 + field;
  endfunction

  task automatic loadBase(input logic [31:0] base);
    @(negedge clk_i);
    load_base_i = 1'b1;
    base_addr_i = base;
    @(posedge clk_i);
    #1;
    load_base_i = 1'b0;
    modelPtr = base & 32'hFFFF_FFFC;
    modelCount = 0;
    checkOutput("load_count", 32'(count_o), 32'(modelCount));
  endtask

  task automatic applyStimulus(input logic [2:0] k, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [4:0] sh, input logic [5:0] fn,
                               input logic [15:0] imm, input logic [31:0] tgt,
                               input int stall);
    bit     ok;
    longint w;
    @(negedge clk_i);
    kind_i = k; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = sh;
    funct_i = fn; imm_i = imm; target_i = tgt;
    mem_ready_i = 1'($urandom_range(0, 1));
    req_valid_i = 1'b1;
    checkOutput("ready_idle", 32'(req_ready_o), 32'd1);
    modelEncode(longint'(k), longint'(rs), longint'(rt), longint'(rd),
                longint'(sh), longint'(fn), longint'(imm), longint'(tgt),
                longint'(modelPtr), ok, w);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    mem_ready_i = 1'b0;
    seenErr  = err_o;
    seenAddr = mem_addr_o;
    seenWord = mem_wdata_o;
    if (ok) begin
      checkOutput("we_rise", 32'(mem_we_o), 32'd1);
      checkOutput("err_low", 32'(err_o), 32'd0);
      checkOutput("addr", mem_addr_o, modelPtr);
      checkOutput("wdata", mem_wdata_o, 32'(w));
      for (int i = 0; i < stall; i++) begin
        @(posedge clk_i);
        #1;
        checkOutput("stall_we", 32'(mem_we_o), 32'd1);
        checkOutput("stall_ready", 32'(req_ready_o), 32'd0);
        checkOutput("stall_addr", mem_addr_o, modelPtr);
        checkOutput("stall_wdata", mem_wdata_o, 32'(w));
      end
      mem_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      mem_ready_i = 1'b0;
      modelPtr = modelPtr + 32'd4;
      if (modelCount < 65535) modelCount++;
      checkOutput("we_fall", 32'(mem_we_o), 32'd0);
      checkOutput("count", 32'(count_o), 32'(modelCount));
    end else begin
      checkOutput("err_pulse", 32'(err_o), 32'd1);
      checkOutput("err_no_we", 32'(mem_we_o), 32'd0);
      @(posedge clk_i);
      #1;
      checkOutput("err_end", 32'(err_o), 32'd0);
      checkOutput("err_ready", 32'(req_ready_o), 32'd1);
      checkOutput("err_count", 32'(count_o), 32'(modelCount));
    end
  endtask

  initial begin
    logic [31:0] tgt;
    int          r;
    rst_i = 1'b0; load_base_i = 1'b0; base_addr_i = '0; req_valid_i = 1'b0;
    kind_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0;
    funct_i = '0; imm_i = '0; target_i = '0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_we", 32'(mem_we_o), 32'd0);
    checkOutput("rst_addr", mem_addr_o, 32'd0);
    checkOutput("rst_wdata", mem_wdata_o, 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rst_count", 32'(count_o), 32'd0);
    rst_i = 1'b1;

    // Request accepted on the first edge after reset release
    applyStimulus(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 32'h0, 0);
    checkOutput("rtype_addr", seenAddr, 32'h0);
    checkOutput("rtype_word", seenWord, 32'h0022_1820);
    checkOutput("rtype_count", 32'(count_o), 32'd1);

    loadBase(32'h100);
    applyStimulus(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0F0, 0);
    checkOutput("beq_word", seenWord, 32'h1022_FFFB);
    applyStimulus(3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 32'h108, 0);
    checkOutput("bne_addr", seenAddr, 32'h104);
    checkOutput("bne_word", seenWord, 32'h1422_0000);

    applyStimulus(3'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'h1234, 32'h0, 5);

    applyStimulus(3'd6, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0, 32'h0, 0);
    checkOutput("kind6_err", 32'(seenErr), 32'd1);
    applyStimulus(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 32'h102, 0);
    checkOutput("misalign_err", 32'(seenErr), 32'd1);
    applyStimulus(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0,
                  modelPtr + 32'd4 + 32'h2_0000, 0);
    checkOutput("range_err", 32'(seenErr), 32'd1);

    // Load and request on the same edge: load wins
    @(negedge clk_i);
    load_base_i = 1'b1; base_addr_i = 32'h203;
    req_valid_i = 1'b1; kind_i = 3'd3;
    @(posedge clk_i);
    #1;
    load_base_i = 1'b0; req_valid_i = 1'b0;
    modelPtr = 32'h200; modelCount = 0;
    checkOutput("lw_no_we", 32'(mem_we_o), 32'd0);
    checkOutput("lw_no_err", 32'(err_o), 32'd0);
    checkOutput("lw_count", 32'(count_o), 32'd0);
    applyStimulus(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h7, 32'h0, 0);
    checkOutput("lw_addr", seenAddr, 32'h200);

    loadBase(32'hFFFF_FFFC);
    applyStimulus(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h1, 32'h0, 1);
    checkOutput("wrap_addr0", seenAddr, 32'hFFFF_FFFC);
    checkOutput("wrap_word0", seenWord, 32'h2008_0001);
    applyStimulus(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h1, 32'h0, 0);
    checkOutput("wrap_addr1", seenAddr, 32'h0);
    checkOutput("wrap_word1", seenWord, 32'h2008_0001);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) loadBase($urandom);
      case ($urandom_range(0, 3))
        0: begin
          r = int'($urandom_range(0, 80000)) - 40000;
          tgt = modelPtr + 32'd4 + 32'(r * 4);
        end
        1: tgt = $urandom;
        2: tgt = modelPtr + 32'($urandom_range(1, 3)) + 32'($urandom_range(0, 64) * 4);
        default: tgt = modelPtr + 32'd4;
      endcase
      applyStimulus(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom),
                    tgt, int'($urandom_range(0, 3)));
    end

    // Reset while a write is pending
    @(negedge clk_i);
    kind_i = 3'd3; rs_i = 5'd1; rt_i = 5'd2; imm_i = 16'hBEEF;
    req_valid_i = 1'b1; mem_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    checkOutput("pre_rst_we", 32'(mem_we_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("async_we", 32'(mem_we_o), 32'd0);
    checkOutput("async_ready", 32'(req_ready_o), 32'd1);
    checkOutput("async_count", 32'(count_o), 32'd0);
    checkOutput("async_addr", mem_addr_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    modelPtr = '0; modelCount = 0;
    applyStimulus(3'd4, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00FF, 32'h0, 0);
    checkOutput("post_rst_addr", seenAddr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
